// File: rtl/param_fifo_pkg.sv
// Shared constants and the pointer-width helper for the param_fifo block.
package param_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_AEMPTY_TH  = 2;

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for param_fifo: synchronous write, asynchronous read.
module fifo_mem
  import param_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  // Contents are intentionally never reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with registered occupancy/threshold flags and sticky overflow/underflow.
// Define PARAM_FIFO_FWFT_EN for first-word-fall-through output; otherwise data_out is a registered read.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = DEF_AEMPTY_TH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          write_en,
  input  logic                          read_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [ptr_width(DEPTH)-1:0]   count,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          err_clr
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

  logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]         count_reg, count_next;
  logic                  full_reg, full_next;
  logic                  empty_reg, empty_next;
  logic                  afull_reg, afull_next;
  logic                  aempty_reg, aempty_next;
  logic                  ovf_reg, ovf_next;
  logic                  udf_reg, udf_next;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr_reg[AW-1:0]),
    .wr_data(data_in),
    .rd_addr(rd_ptr_reg[AW-1:0]),
    .rd_data(mem_rd_data)
  );

  // Acceptance uses the registered flags, so at full a simultaneous read wins and at empty the write wins.
  always_comb begin
    wr_acc      = write_en & ~full_reg;
    rd_acc      = read_en & ~empty_reg;
    wr_ptr_next = wr_ptr_reg + PW'(wr_acc);
    rd_ptr_next = rd_ptr_reg + PW'(rd_acc);
    count_next  = wr_ptr_next - rd_ptr_next;
    full_next   = (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]) &&
                  (wr_ptr_next[AW] != rd_ptr_next[AW]);
    empty_next  = (wr_ptr_next == rd_ptr_next);
    afull_next  = (count_next >= AFULL_C);
    aempty_next = (count_next <= AEMPTY_C);
    // A fresh error outranks a same-cycle clear.
    ovf_next    = (write_en & full_reg) | (ovf_reg & ~err_clr);
    udf_next    = (read_en & empty_reg) | (udf_reg & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      afull_reg  <= 1'b0;
      aempty_reg <= 1'b1;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      full_reg   <= full_next;
      empty_reg  <= empty_next;
      afull_reg  <= afull_next;
      aempty_reg <= aempty_next;
      ovf_reg    <= ovf_next;
      udf_reg    <= udf_next;
    end
  end

`ifdef PARAM_FIFO_FWFT_EN
  assign data_out = empty_reg ? '0 : mem_rd_data;
`else
  logic [DATA_WIDTH-1:0] data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
    end else if (rd_acc) begin
      data_reg <= mem_rd_data;
    end
  end

  assign data_out = data_reg;
`endif

  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = afull_reg;
  assign almost_empty = aempty_reg;
  assign count        = count_reg;
  assign overflow     = ovf_reg;
  assign underflow    = udf_reg;

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 8, which is the data bit width (>=1).
REQ-002 The block SHALL take parameter DEPTH, default 16, which is the entry count (power of two, >=4).
REQ-003 The block SHALL take parameter AFULL_TH, default DEPTH-2, which is the count at or above which almost_full asserts.
REQ-004 The block SHALL take parameter AEMPTY_TH, default 2, which is the count at or below which almost_empty asserts.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, with all state on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port write_en, input, 1 bit: push request.
REQ-008 The block SHALL have port read_en, input, 1 bit: pop request.
REQ-009 The block SHALL have port data_in, input, DATA_WIDTH bits: push data.
REQ-010 The block SHALL have port data_out, output, DATA_WIDTH bits: pop data.
REQ-011 The block SHALL have ports full and empty, output, 1 bit each: occupancy == DEPTH and occupancy == 0.
REQ-012 The block SHALL have ports almost_full and almost_empty, output, 1 bit each: threshold flags.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy 0..DEPTH.
REQ-014 The block SHALL have ports overflow and underflow, output, 1 bit each: sticky error flags.
REQ-015 The block SHALL have port err_clr, input, 1 bit: synchronous clear of overflow and underflow.

Function
REQ-016 The block SHALL accept a write only when write_en=1 and full=0, storing data_in at wr_ptr and advancing wr_ptr by 1.
REQ-017 The block SHALL accept a read only when read_en=1 and empty=0, advancing rd_ptr by 1.
REQ-018 The block SHALL use pointers of $clog2(DEPTH)+1 bits, with the MSB as wrap bit: full when addresses are equal and MSBs differ, empty when the pointers are fully equal.
REQ-019 The block SHALL evaluate acceptance against the flag values present before the edge; when write and read both occur at count=DEPTH, the read SHALL be accepted and the write rejected.
REQ-020 When write and read both occur at count=0, the block SHALL accept the write and reject the read.
REQ-021 When write and read are both accepted, the block SHALL leave count unchanged and advance both pointers.
REQ-022 The block SHALL drive count, full, empty, almost_full and almost_empty from registers, all valid one cycle after the causing edge.
REQ-023 The block SHALL assert almost_full when count>=AFULL_TH and almost_empty when count<=AEMPTY_TH.
REQ-024 A rejected write (write_en=1 with full=1) SHALL set overflow=1; a rejected read (read_en=1 with empty=1) SHALL set underflow=1; both SHALL hold until err_clr=1 or reset.
REQ-025 If err_clr=1 coincides with a new error in the same cycle, the new error SHALL win and the flag SHALL remain 1.
REQ-026 A rejected access SHALL alter no pointer, count or memory content.
REQ-027 In standard mode, data_out SHALL be registered: it is loaded with the head entry on the edge that accepts a read (1-cycle latency) and holds its value otherwise.

Reset
REQ-028 rst_n=0 SHALL immediately, asynchronously clear both pointers, count, data_out, overflow and underflow to 0, with empty=1, almost_empty=1, full=0 and almost_full=0.
REQ-029 Memory contents SHALL NOT be reset, and entries present before a mid-operation reset SHALL be discarded.

Configuration
REQ-030 With macro PARAM_FIFO_FWFT_EN defined, the block SHALL operate first-word-fall-through: data_out shows the head entry whenever empty=0, and read_en pops it.
REQ-031 In FWFT mode, data_out SHALL be valid the cycle after the first write into an empty FIFO, and SHALL be 0 while empty.
REQ-032 With PARAM_FIFO_FWFT_EN undefined, the block SHALL use the standard registered read of REQ-027.

Structure
REQ-033 A shared package param_fifo_pkg SHALL hold the pointer-width function and default parameter constants.
REQ-034 The block SHALL contain exactly one sub-module, fifo_mem: a simple dual-port RAM with synchronous write and asynchronous read, DATA_WIDTH x DEPTH.

Verification
REQ-035 The bench SHALL cover reset: after reset -> empty=1, full=0, count=0, data_out=0, overflow=0, underflow=0.
REQ-036 The bench SHALL cover fill to full: write 0x01..0x10 (DEPTH=16) -> almost_full=1 at count=14, full=1 after the 16th write; a 17th write -> overflow=1 with count=16.
REQ-037 The bench SHALL cover drain: read 16 times -> data 0x01..0x10 in order (standard mode: 1 cycle after each read edge), then empty=1; an extra read -> underflow=1; err_clr=1 -> both flags 0.
REQ-038 The bench SHALL cover wrap-around: write 10, read 10, write 12, read 12 -> order preserved across pointer wrap, and count=0 at the end.
REQ-039 The bench SHALL cover simultaneous access: read+write at count=5 -> count=5; read+write at count=16 -> count=15 and overflow=1; read+write at count=0 -> count=1 and underflow=1.
REQ-040 The bench SHALL cover mid-operation reset: rst_n low at count=7 -> without waiting for a clock edge, count=0, empty=1; the next write of 0xA5 then a read -> 0xA5 out.
